// File: rtl/usart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encoding, parity modes,
// status register layout and the default bit period.
package usart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned ST_OVR  = 7;
  localparam int unsigned ST_FERR = 6;
  localparam int unsigned ST_PERR = 5;
  localparam int unsigned ST_FULL = 4;

  // 32 MHz / 9600 baud
  localparam int unsigned DEFAULT_CPB = 3333;

  // Data must be zero above the frame width so the reduction covers only real bits.
  function automatic logic parity_error(logic [7:0] data, logic par_bit, int unsigned parity);
    return (^data ^ par_bit) != (parity == PARITY_ODD);
  endfunction

endpackage

// File: rtl/usart_fifo.sv
// Small synchronous FIFO; a push while full succeeds only alongside a pop.
module usart_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  output logic [Width-1:0] dout_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = count_q == CntW'(Depth);
  assign empty_o = count_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/usart_rx_fifo.sv
// UART receiver with runtime bit period, optional parity, a receive FIFO and a
// bus-readable status register with sticky error flags.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter logic [7:0]  ADDR       = 8'h00,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CPB_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [CPB_W-1:0] clk_per_bit,
  input  logic [7:0]       address,
  input  logic             ren,
  output logic [7:0]       port_out,
  output logic             int_rx
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e        state_q;
  logic             rx_meta_q, rx_s_q;
  logic [CPB_W-1:0] cnt_q, cpb_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       data_q;
  logic             par_q;
  logic             ovr_q, ferr_q, perr_q;
  logic [7:0]       port_out_q;
  logic             int_rx_q;

  logic [CntW-1:0]  fifo_count;
  logic [7:0]       fifo_dout, status;
  logic             fifo_full, fifo_empty;
  logic             sample_tick, half_tick, frame_end, par_bad;
  logic             rd_data, rd_status, push, pop;
  logic             ovr_set, ferr_set, perr_set;

  assign sample_tick = cnt_q == cpb_q - CPB_W'(1);
  assign half_tick   = cnt_q == (cpb_q >> 1) - CPB_W'(1);
  assign frame_end   = (state_q == StStop) && sample_tick;
  assign par_bad     = (PARITY != PARITY_NONE) && parity_error(data_q, par_q, PARITY);

  assign rd_data   = ren && (address == ADDR);
  assign rd_status = ren && (address == ADDR + 8'd1);
  assign pop       = rd_data && !fifo_empty;

  // Resolution priority: framing, then parity, then overrun.
  assign ferr_set = frame_end && !rx_s_q;
  assign perr_set = frame_end && rx_s_q && par_bad;
  assign ovr_set  = frame_end && rx_s_q && !par_bad && fifo_full && !pop;
  assign push     = frame_end && rx_s_q && !par_bad && (!fifo_full || pop);

  always_comb begin
    status          = '0;
    status[ST_OVR]  = ovr_q;
    status[ST_FERR] = ferr_q;
    status[ST_PERR] = perr_q;
    status[ST_FULL] = fifo_full;
    status[3:0]     = 4'(fifo_count);
  end

  usart_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (data_q),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cpb_q     <= CPB_W'(DEFAULT_CPB);
      bit_idx_q <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
            cpb_q   <= clk_per_bit;
            data_q  <= '0;
          end
        end
        StStart: begin
          if (half_tick) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        StData: begin
          if (sample_tick) begin
            cnt_q             <= '0;
            data_q[bit_idx_q] <= rx_s_q;
            bit_idx_q         <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= (PARITY != PARITY_NONE) ? StPar : StStop;
            end
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        StPar: begin
          if (sample_tick) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        StStop: begin
          // Back to idle mid-stop so an immediately following start bit is seen.
          if (sample_tick) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CPB_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      port_out_q <= '0;
      int_rx_q   <= 1'b0;
    end else begin
      // A flag raised in the same cycle as a status read survives the clear.
      ovr_q    <= (ovr_q && !rd_status) || ovr_set;
      ferr_q   <= (ferr_q && !rd_status) || ferr_set;
      perr_q   <= (perr_q && !rd_status) || perr_set;
      int_rx_q <= fifo_count != '0;
      if (rd_data) begin
        port_out_q <= fifo_empty ? 8'h00 : fifo_dout;
      end else if (rd_status) begin
        port_out_q <= status;
      end
    end
  end

  assign port_out = port_out_q;
  assign int_rx   = int_rx_q;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Randomised bench for usart_rx_fifo: two instances (8N1 and 7E1) checked against
// a queue-based model of the receive FIFO and sticky flags.
module tb_usart_rx_fifo;

  localparam logic [7:0] ADDR1 = 8'h10;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rx0, rx1, ren;
  logic [11:0] cpb;
  logic [7:0]  address, po0, po1;
  logic        int0, int1;

  always #5 clk = ~clk;

  usart_rx_fifo u_dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx0),
    .clk_per_bit(cpb),
    .address    (address),
    .ren        (ren),
    .port_out   (po0),
    .int_rx     (int0)
  );

  usart_rx_fifo #(
    .ADDR     (ADDR1),
    .DATA_BITS(7),
    .PARITY   (1)
  ) u_par (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx1),
    .clk_per_bit(cpb),
    .address    (address),
    .ren        (ren),
    .port_out   (po1),
    .int_rx     (int1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [2:0] mflg[2];  // {ovr, ferr, perr}

  task automatic check_eq(string tag, logic [7:0] got, logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic model_frame(int sel, logic [7:0] data, logic stop, logic pb);
    logic [7:0] d;
    int sz;
    d  = (sel == 0) ? data : (data & 8'h7f);
    sz = (sel == 0) ? mq0.size() : mq1.size();
    if (!stop) mflg[sel][1] = 1'b1;
    else if (sel == 1 && (^d ^ pb) != 1'b0) mflg[sel][0] = 1'b1;
    else if (sz == DEPTH) mflg[sel][2] = 1'b1;
    else if (sel == 0) mq0.push_back(d);
    else mq1.push_back(d);
  endtask

  task automatic model_read_data(int sel, output logic [7:0] exp);
    exp = 8'h00;
    if (sel == 0 && mq0.size() > 0) exp = mq0.pop_front();
    if (sel == 1 && mq1.size() > 0) exp = mq1.pop_front();
  endtask

  task automatic model_read_status(int sel, output logic [7:0] exp);
    int sz;
    sz  = (sel == 0) ? mq0.size() : mq1.size();
    exp = {mflg[sel], (sz == DEPTH) ? 1'b1 : 1'b0, 4'(sz)};
    mflg[sel] = 3'b000;
  endtask

  task automatic set_rx(int sel, logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Called at a negedge; the start bit is driven immediately.
  task automatic send_frame(int sel, int c, logic [7:0] data, logic stop, logic pb, int gap);
    int n;
    n   = (sel == 0) ? 8 : 7;
    cpb = 12'(c);
    set_rx(sel, 1'b0);
    repeat (c) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, data[i]);
      repeat (c) @(negedge clk);
    end
    if (sel == 1) begin
      set_rx(sel, pb);
      repeat (c) @(negedge clk);
    end
    set_rx(sel, stop);
    repeat (c) @(negedge clk);
    set_rx(sel, 1'b1);
    model_frame(sel, data, stop, pb);
    repeat (gap) @(negedge clk);
  endtask

  task automatic bus_read(logic [7:0] a, output logic [7:0] got);
    address = a;
    ren     = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    got = (a >= ADDR1) ? po1 : po0;
  endtask

  task automatic chk_data(int sel, string tag);
    logic [7:0] exp, got;
    model_read_data(sel, exp);
    bus_read((sel == 0) ? 8'h00 : ADDR1, got);
    check_eq(tag, got, exp);
  endtask

  task automatic chk_status(int sel, string tag);
    logic [7:0] exp, got;
    model_read_status(sel, exp);
    bus_read((sel == 0) ? 8'h01 : ADDR1 + 8'd1, got);
    check_eq(tag, got, exp);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, pb;
    int         sel, act, c, gap;

    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ren = 1'b0; address = 8'h00; cpb = 12'd3333;
    mflg[0] = 3'b000; mflg[1] = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_port_out", po0, 8'h00);
    check_eq("rst_int_rx", {7'b0, int0}, 8'h00);
    @(negedge clk);
    chk_status(0, "rst_status");

    // Full-speed default frame
    send_frame(0, 3333, 8'haf, 1'b1, 1'b0, 20);
    check_eq("t1_int_high", {7'b0, int0}, 8'h01);
    chk_data(0, "t1_data");
    @(negedge clk);
    check_eq("t1_int_low", {7'b0, int0}, 8'h00);

    // Back-to-back overrun
    send_frame(0, 16, 8'h53, 1'b1, 1'b0, 0);
    send_frame(0, 16, 8'h01, 1'b1, 1'b0, 0);
    send_frame(0, 16, 8'hff, 1'b1, 1'b0, 0);
    send_frame(0, 16, 8'h7e, 1'b1, 1'b0, 0);
    send_frame(0, 16, 8'h10, 1'b1, 1'b0, 4);
    chk_status(0, "t2_status");
    for (int i = 0; i < 5; i++) chk_data(0, "t2_data");
    chk_status(0, "t2_status_clr");

    // Start glitch
    cpb = 12'd20;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("t3_int", {7'b0, int0}, 8'h00);
    chk_status(0, "t3_status");
    send_frame(0, 20, 8'h96, 1'b1, 1'b0, 4);
    chk_data(0, "t3_recover");

    // Framing error
    send_frame(0, 16, 8'ha5, 1'b0, 1'b0, 32);
    chk_status(0, "t4_ferr");
    chk_status(0, "t4_clr");
    check_eq("t4_int", {7'b0, int0}, 8'h00);

    // Status read coinciding with the overrun stop sample
    for (int i = 0; i < 4; i++) send_frame(0, 16, 8'(8'h20 + i), 1'b1, 1'b0, 2);
    fork
      send_frame(0, 16, 8'h3c, 1'b1, 1'b0, 8);
      begin
        repeat (2 + 8 + 9 * 16) @(negedge clk);
        chk_status(0, "t6_same_cycle");
      end
    join
    chk_status(0, "t6_ovr_kept");
    for (int i = 0; i < 4; i++) chk_data(0, "t6_drain");

    // Reset in the middle of the data bits
    send_frame(0, 16, 8'h5a, 1'b1, 1'b0, 2);
    send_frame(0, 16, 8'h66, 1'b1, 1'b0, 2);
    chk_data(0, "t7_pre");
    cpb = 12'd16;
    rx0 = 1'b0;
    repeat (48) @(negedge clk);
    rst = 1'b1;
    rx0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq0.delete(); mq1.delete();
    mflg[0] = 3'b000; mflg[1] = 3'b000;
    check_eq("t7_port_out", po0, 8'h00);
    check_eq("t7_int", {7'b0, int0}, 8'h00);
    repeat (40) @(negedge clk);
    chk_status(0, "t7_status");
    send_frame(0, 16, 8'hc3, 1'b1, 1'b0, 4);
    chk_data(0, "t7_after");

    // 7E1 instance: good then bad parity
    send_frame(1, 16, 8'h35, 1'b1, 1'b0, 8);
    send_frame(1, 16, 8'h35, 1'b1, 1'b1, 8);
    chk_status(1, "t5_status");
    chk_data(1, "t5_data");
    chk_data(1, "t5_empty");

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 1));
      act = int'($urandom_range(0, 3));
      c   = 2 * int'($urandom_range(4, 20));
      if (act <= 1) begin
        d    = 8'($urandom);
        stop = ($urandom_range(0, 7) != 0);
        pb   = ^(d & 8'h7f) ^ ($urandom_range(0, 3) == 0);
        gap  = stop ? int'($urandom_range(0, 4)) : c + 4;
        send_frame(sel, c, d, stop, pb, gap);
        repeat (2) @(negedge clk);
      end else if (act == 2) begin
        chk_data(sel, "rnd_data");
      end else begin
        chk_status(sel, "rnd_status");
      end
    end
    repeat (8) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk_status(s, "end_status");
      for (int i = 0; i < 5; i++) chk_data(s, "end_data");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usart_rx_fifo.md
Name: usart_rx_fifo

Overview:
Parametrised successor to the single-byte bus-mapped UART receiver. It deserialises asynchronous frames with a runtime-set bit period and configurable data width and parity. Accepted characters are queued in a small FIFO and read over the same 8-bit peripheral bus (address/ren/port_out). A second address exposes a status register with sticky error flags.

Parameters:
ADDR, 8'h00, bus address of data register; status register is at ADDR+1
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
FIFO_DEPTH, 4, entries, power of two, legal 2..8
CPB_W, 12, width of clk_per_bit

Ports:
clk  in  1  system clock (32 MHz nominal)
rst  in  1  synchronous active-high reset
rx  in  1  asynchronous serial input, idle high
clk_per_bit  in  CPB_W  clocks per bit; legal >= 4
address  in  8  bus address
ren  in  1  read strobe, one cycle per access
port_out  out  8  registered read data
int_rx  out  1  high while FIFO not empty

Behaviour:
- Reset (rst=1 at clk edge): FSM IDLE, FIFO empty, sticky flags 0, port_out=0, int_rx=0. Reset mid-frame abandons the frame with no push and no flags.
- rx passes a 2-flop synchroniser (2-cycle delay) before any use; reset value of both flops is 1.
- clk_per_bit is latched on start detection and held constant for the whole frame.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a synchronised falling level (rx_s=0), go to START and clear the counter.
  - START: at count = cpb/2 - 1, if rx_s=1, treat as a glitch and return to IDLE. Otherwise reset the counter and enter DATA; all later samples fall mid-bit.
  - DATA: sample every cpb clocks, LSB first, DATA_BITS samples. Then go to PAR if PARITY != 0, else STOP.
  - PAR: sample one bit. Error if the XOR of data and parity bit is not 0 (even) or not 1 (odd).
  - STOP: sample one bit, then return to IDLE in the same cycle so that a back-to-back start bit is caught.
- Frame resolution happens in the STOP sample cycle, in this priority order:
  - stop=0: set ferr and discard the byte.
  - else parity error: set perr and discard the byte.
  - else FIFO full with no simultaneous pop: set ovr and discard the byte.
  - else push the byte, zero-extended to 8 bits.
- FIFO: circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits, wrapping naturally. count is 0..FIFO_DEPTH.
  - Simultaneous push and pop: both occur and count is unchanged. A push to a full FIFO is accepted if a pop occurs in the same cycle.
- Bus reads are decoded only when ren=1. port_out updates on the next clock edge (1-cycle latency) and otherwise holds its last value.
  - address==ADDR, FIFO not empty: port_out = head, and pop.
  - address==ADDR, FIFO empty: port_out = 0, no pop, no flag change.
  - address==ADDR+1: port_out = {ovr, ferr, perr, full, count[3:0]}. In the same edge, clear ovr, ferr and perr. An error occurring in that same cycle wins and its flag stays set.
  - Any other address: no effect.
- int_rx is registered: int_rx = (count != 0) after each edge. It falls in the cycle after the read that empties the FIFO.
- clk_per_bit < 4 is undefined; the bench does not drive it.

Decomposition:
- Shared package usart_pkg:
  - FSM state encoding
  - PARITY_NONE/EVEN/ODD constants
  - status bit indices (ST_OVR=7, ST_FERR=6, ST_PERR=5, ST_FULL=4)
  - default CPB (32 MHz / 9600 = 3333)
- Sub-module usart_fifo: synchronous FIFO parametrised by width and depth, with push, pop, dout, count, full and empty. The receiver FSM, synchroniser and bus decode stay in usart_rx_fifo.

Test Plan:
1. Defaults, cpb=3333, UART_TX sends 8'hAF -> int_rx rises about 10 bit times after the start; a read at ADDR gives port_out=8'hAF next cycle and int_rx=0 one cycle later.
2. Send 8'h53, 8'h01, 8'hFF, 8'h7E, 8'h10 back-to-back with no reads -> status reads 8'h94 (ovr, full, count 4). Later data reads return 53, 01, FF, 7E, then 00 on empty. A second status read gives 8'h00.
3. Drive rx low for 4 clocks only -> FSM returns to IDLE, no push, no flags, int_rx stays 0.
4. Hand-driven frame with stop bit = 0, data 8'hA5 -> no push, status = 8'h40; re-read gives 8'h00.
5. PARITY=1, DATA_BITS=7: send 7'h35 with correct even parity, then with a wrong parity bit -> one entry 8'h35; status = 8'h21 (perr, count 1).
6. Status read in the same cycle as the STOP sample of an overrunning frame -> the read returns the old flags and ovr remains set afterwards. Also assert rst mid-DATA -> all outputs return to 0 and a subsequent frame is received correctly.
